// File: rtl/timer_irq_controller.sv
// timer_irq_controller: prioritised timer interrupt request/ack/RETI sequencer
module timer_irq_controller #(
  parameter int VEC_W         = 14,
  parameter int VECTOR_BASE   = 6,
  parameter int VECTOR_STRIDE = 2,
  parameter int RETI_HOLDOFF  = 1
) (
  input  logic             sysClock,
  input  logic             rst,
  input  logic [7:0]       TIFR_in,
  input  logic [7:0]       TIMSK_in,
  input  logic             sreg_i,
  input  logic             cpu_ack,
  input  logic             reti,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vector,
  output logic             tifr_clear_en,
  output logic [7:0]       tifr_clear_mask,
  output logic             gie_clear,
  output logic             in_service
);
  typedef enum logic [2:0] {IDLE, REQ, ACK, SERVICE, HOLD} state_t;
  state_t state_q, state_d;
  logic [2:0] win_q, win_d, win;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pending;
  logic [VEC_W-1:0] vec;
  assign pending = TIFR_in & TIMSK_in;
  always_comb begin
    win = 3'd0;
    for (int i = 0; i < 8; i++) win = pending[i] ? 3'(i) : win;
  end
  assign vec = VEC_W'(VECTOR_BASE) + VEC_W'(VECTOR_STRIDE) * VEC_W'(3'd7 - win_q);
  always_ff @(posedge sysClock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end
  // winner is latched on entry to REQ so the vector cannot move under the CPU
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (sreg_i && |pending) begin
        state_d = REQ;
        win_d   = win;
      end
      REQ: state_d = cpu_ack ? ACK : (!pending[win_q] || !sreg_i) ? IDLE : REQ;
      ACK: state_d = SERVICE;
      SERVICE: if (reti) begin
        state_d = (RETI_HOLDOFF == 0) ? IDLE : HOLD;
        cnt_d   = 4'(RETI_HOLDOFF);
      end
      HOLD: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q <= 4'd1) ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  assign irq_req         = state_q == REQ;
  assign irq_vector      = irq_req ? vec : '0;
  assign tifr_clear_en   = state_q == ACK;
  assign tifr_clear_mask = tifr_clear_en ? 8'b1 << win_q : 8'd0;
  assign gie_clear       = tifr_clear_en;
  assign in_service      = (state_q == ACK) || (state_q == SERVICE);
endmodule

// File: tb/tb_timer_irq_controller.sv
// tb_timer_irq_controller: directed checks of arbitration, handshake, holdoff and reset
module tb_timer_irq_controller;
  logic sysClock = 0, rst = 1, sreg_i = 0, cpu_ack = 0, reti = 0;
  logic [7:0] TIFR_in = 0, TIMSK_in = 0;
  logic irq_req, tifr_clear_en, gie_clear, in_service;
  logic [13:0] irq_vector;
  logic [7:0] tifr_clear_mask;
  int total = 0, bad = 0;
  timer_irq_controller dut (
    .sysClock(sysClock), .rst(rst), .TIFR_in(TIFR_in), .TIMSK_in(TIMSK_in), .sreg_i(sreg_i),
    .cpu_ack(cpu_ack), .reti(reti), .irq_req(irq_req), .irq_vector(irq_vector),
    .tifr_clear_en(tifr_clear_en), .tifr_clear_mask(tifr_clear_mask), .gie_clear(gie_clear),
    .in_service(in_service)
  );
  always #5 sysClock = ~sysClock;
  wire [25:0] outs = {irq_req, irq_vector, tifr_clear_en, tifr_clear_mask, gie_clear, in_service};
  task automatic tick;
    @(posedge sysClock);
    #1;
  endtask
  task automatic test_reset;
    tick;
    total++; if (outs !== 26'd0) begin bad++; $display("FAIL reset_outs got %h exp 0", outs); end
    rst = 0;
    tick;
    total++; if (outs !== 26'd0) begin bad++; $display("FAIL post_reset_outs got %h exp 0", outs); end
  endtask
  task automatic test_basic;
    TIMSK_in = 8'h01; sreg_i = 1; TIFR_in = 8'h00;
    tick;
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL basic_idle irq_req got %b exp 0", irq_req); end
    TIFR_in = 8'h01;
    tick;
    total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL basic_req irq_req got %b exp 1", irq_req); end
    total++; if (irq_vector !== 14'h014) begin bad++; $display("FAIL basic_vec got %h exp 014", irq_vector); end
    cpu_ack = 1;
    tick;
    cpu_ack = 0; sreg_i = 0;
    total++; if ({tifr_clear_en, tifr_clear_mask, gie_clear, in_service, irq_req} !== {1'b1, 8'h01, 1'b1, 1'b1, 1'b0})
      begin bad++; $display("FAIL basic_ack got en=%b mask=%h gie=%b svc=%b req=%b exp 1 01 1 1 0", tifr_clear_en, tifr_clear_mask, gie_clear, in_service, irq_req); end
    TIFR_in = 8'h00;
    tick;
    total++; if ({tifr_clear_en, tifr_clear_mask, gie_clear, in_service} !== {1'b0, 8'h00, 1'b0, 1'b1})
      begin bad++; $display("FAIL basic_service got en=%b mask=%h gie=%b svc=%b exp 0 00 0 1", tifr_clear_en, tifr_clear_mask, gie_clear, in_service); end
    reti = 1; sreg_i = 1;
    tick;
    reti = 0;
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL basic_reti in_service got %b exp 0", in_service); end
    tick; tick;
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL basic_no_rereq irq_req got %b exp 0", irq_req); end
  endtask
  task automatic test_priority;
    TIMSK_in = 8'hFF; TIFR_in = 8'h15;
    tick;
    total++; if (irq_vector !== 14'h00C) begin bad++; $display("FAIL prio_vec got %h exp 00C", irq_vector); end
    cpu_ack = 1;
    tick;
    cpu_ack = 0; sreg_i = 0;
    total++; if (tifr_clear_mask !== 8'h10) begin bad++; $display("FAIL prio_mask got %h exp 10", tifr_clear_mask); end
    TIFR_in = 8'h05;
    tick;
    reti = 1; sreg_i = 1;
    tick;
    reti = 0;
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL prio_hold irq_req got %b exp 0", irq_req); end
    tick;
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL prio_idle irq_req got %b exp 0", irq_req); end
    tick;
    total++; if ({irq_req, irq_vector} !== {1'b1, 14'h010}) begin bad++; $display("FAIL prio_rereq got req=%b vec=%h exp 1 010", irq_req, irq_vector); end
  endtask
  task automatic test_withdraw;
    TIFR_in = 8'h00;
    tick;
    total++; if ({irq_req, tifr_clear_en, in_service} !== 3'b000) begin bad++; $display("FAIL withdraw got req=%b en=%b svc=%b exp 0 0 0", irq_req, tifr_clear_en, in_service); end
    cpu_ack = 1;
    tick;
    cpu_ack = 0;
    total++; if ({tifr_clear_en, in_service} !== 2'b00) begin bad++; $display("FAIL stray_ack got en=%b svc=%b exp 0 0", tifr_clear_en, in_service); end
  endtask
  task automatic test_ack_wins;
    TIFR_in = 8'h80;
    tick;
    total++; if (irq_vector !== 14'h006) begin bad++; $display("FAIL ackwin_vec got %h exp 006", irq_vector); end
    cpu_ack = 1; sreg_i = 0;
    tick;
    cpu_ack = 0;
    total++; if ({tifr_clear_en, tifr_clear_mask, in_service} !== {1'b1, 8'h80, 1'b1})
      begin bad++; $display("FAIL ackwin got en=%b mask=%h svc=%b exp 1 80 1", tifr_clear_en, tifr_clear_mask, in_service); end
    TIFR_in = 8'h00;
    tick;
    reti = 1; sreg_i = 1;
    tick;
    reti = 0;
    tick; tick;
  endtask
  task automatic test_gie_gate;
    TIFR_in = 8'h04; TIMSK_in = 8'h04; sreg_i = 0;
    tick; tick;
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL gie_block irq_req got %b exp 0", irq_req); end
    sreg_i = 1;
    tick;
    total++; if ({irq_req, irq_vector} !== {1'b1, 14'h010}) begin bad++; $display("FAIL gie_open got req=%b vec=%h exp 1 010", irq_req, irq_vector); end
    reti = 1;
    tick;
    reti = 0;
    total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL stray_reti irq_req got %b exp 1", irq_req); end
  endtask
  task automatic test_async_reset;
    cpu_ack = 1;
    tick;
    cpu_ack = 0;
    tick;
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL rst_pre_service got %b exp 1", in_service); end
    rst = 1;
    #1;
    total++; if (outs !== 26'd0) begin bad++; $display("FAIL rst_in_service got %h exp 0", outs); end
    tick;
    rst = 0;
    #1;
    total++; if (outs !== 26'd0) begin bad++; $display("FAIL rst_release got %h exp 0", outs); end
    tick;
    total++; if ({irq_req, irq_vector} !== {1'b1, 14'h010}) begin bad++; $display("FAIL rst_rereq1 got req=%b vec=%h exp 1 010", irq_req, irq_vector); end
    rst = 1;
    #1;
    total++; if (outs !== 26'd0) begin bad++; $display("FAIL rst_in_req got %h exp 0", outs); end
    tick;
    rst = 0;
    tick;
    total++; if ({irq_req, irq_vector} !== {1'b1, 14'h010}) begin bad++; $display("FAIL rst_rereq2 got req=%b vec=%h exp 1 010", irq_req, irq_vector); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_withdraw;
    test_ack_wins;
    test_gie_gate;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
